// File: rtl/zpc_mem_pkg.sv
// Shared definitions for the two-master main-memory arbiter: FSM encoding and port indices.
package zpc_mem_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT
    } state_e;

    localparam logic P_CPU = 1'b0;
    localparam logic P_AUX = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way picker: lone requester wins; on a tie either the port
// that did not win last time (round-robin) or the CPU port (fixed priority).
module rr_arb2 import zpc_mem_pkg::*; (
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       rr_en_i,
    output logic       gnt_idx_o
);
    always_comb begin
        gnt_idx_o = P_CPU;
        if (req_i == 2'b10)
            gnt_idx_o = P_AUX;
        else if (req_i == 2'b11 && rr_en_i)
            gnt_idx_o = ~last_i;
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port memory between CPU (port 0) and an auxiliary master (port 1),
// one transaction in flight, all outputs registered.
module mem_arbiter import zpc_mem_pkg::*; #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1,
    parameter int RR      = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    if (MEM_LAT < 1) begin : g_bad_lat
        $error("mem_arbiter: MEM_LAT must be >= 1");
    end

    localparam int CW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic          win_q, win_d;
    logic          we_q, we_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    rvalid_q, rvalid_d;
    logic          rd_q, rd_d, wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [1:0]    req;
    logic          pick;

    assign req = {m1_req, m0_req};

    rr_arb2 u_arb (
        .req_i     (req),
        .last_i    (last_q),
        .rr_en_i   (RR != 0),
        .gnt_idx_o (pick)
    );

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        win_d    = win_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        gnt_d    = 2'b00;
        rvalid_d = 2'b00;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        unique case (state_q)
            S_IDLE: if (|req) begin
                // Winner's fields go straight into the output registers so the
                // strobe, address and grant all appear together in ISSUE.
                state_d     = S_ISSUE;
                last_d      = pick;
                win_d       = pick;
                we_d        = pick ? m1_we    : m0_we;
                addr_d      = pick ? m1_addr  : m0_addr;
                wdata_d     = pick ? m1_wdata : m0_wdata;
                gnt_d[pick] = 1'b1;
                rd_d        = ~we_d;
                wr_d        = we_d;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = CW'(MEM_LAT);
            end
            S_WAIT: begin
                if (cnt_q == CW'(1)) begin
                    state_d         = S_IDLE;
                    rvalid_d[win_q] = 1'b1;
                    if (!we_q) begin
                        if (win_q) rdata1_d = mem_rdata;
                        else       rdata0_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            last_q   <= P_AUX;
            win_q    <= P_CPU;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            gnt_q    <= 2'b00;
            rvalid_q <= 2'b00;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            win_q    <= win_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign m0_gnt    = gnt_q[0];
    assign m1_gnt    = gnt_q[1];
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign mem_rd    = rd_q;
    assign mem_wr    = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: instance a is round-robin with MEM_LAT=1, instance b is fixed
// priority with MEM_LAT=3; each has a memory model that is only valid at the exact latency.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   a_gn = 0, a_rvn = 0, b_gn = 0, b_rvn = 0;

    always #5 clk = ~clk;

    logic [1:0]  a_req = '0, a_we = '0, b_req = '0, b_we = '0;
    logic [31:0] a_addr [2], a_wd [2], b_addr [2], b_wd [2];
    wire  [1:0]  a_gnt, a_rv, b_gnt, b_rv;
    wire  [31:0] a_rdata [2], b_rdata [2];
    wire         a_mrd, a_mwr, b_mrd, b_mwr;
    wire  [31:0] a_maddr, a_mwd, b_maddr, b_mwd;
    logic [31:0] a_mrdata, b_mrdata;

    initial begin
        for (int i = 0; i < 2; i++) begin
            a_addr[i] = '0; a_wd[i] = '0; b_addr[i] = '0; b_wd[i] = '0;
        end
    end

    function automatic logic [31:0] memval(input logic [31:0] addr);
        return (addr == 32'h10) ? 32'hDEADBEEF : (addr ^ 32'hA5A5_0000);
    endfunction

    // Memory returns data only MEM_LAT cycles after the read strobe, garbage otherwise.
    logic [2:0]  a_pipe = '0, b_pipe = '0;
    logic [31:0] a_la = '0, b_la = '0;
    always @(posedge clk) begin
        a_pipe <= {a_pipe[1:0], a_mrd};
        b_pipe <= {b_pipe[1:0], b_mrd};
        if (a_mrd) a_la <= a_maddr;
        if (b_mrd) b_la <= b_maddr;
    end
    assign a_mrdata = a_pipe[0] ? memval(a_la) : 32'hBAD0BAD0;
    assign b_mrdata = b_pipe[2] ? memval(b_la) : 32'hBAD0BAD0;

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .RR(1)) u_a (
        .clk(clk), .rst(rst),
        .m0_req(a_req[0]), .m0_we(a_we[0]), .m0_addr(a_addr[0]), .m0_wdata(a_wd[0]),
        .m0_gnt(a_gnt[0]), .m0_rvalid(a_rv[0]), .m0_rdata(a_rdata[0]),
        .m1_req(a_req[1]), .m1_we(a_we[1]), .m1_addr(a_addr[1]), .m1_wdata(a_wd[1]),
        .m1_gnt(a_gnt[1]), .m1_rvalid(a_rv[1]), .m1_rdata(a_rdata[1]),
        .mem_rd(a_mrd), .mem_wr(a_mwr), .mem_addr(a_maddr), .mem_wdata(a_mwd),
        .mem_rdata(a_mrdata)
    );

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .RR(0)) u_b (
        .clk(clk), .rst(rst),
        .m0_req(b_req[0]), .m0_we(b_we[0]), .m0_addr(b_addr[0]), .m0_wdata(b_wd[0]),
        .m0_gnt(b_gnt[0]), .m0_rvalid(b_rv[0]), .m0_rdata(b_rdata[0]),
        .m1_req(b_req[1]), .m1_we(b_we[1]), .m1_addr(b_addr[1]), .m1_wdata(b_wd[1]),
        .m1_gnt(b_gnt[1]), .m1_rvalid(b_rv[1]), .m1_rdata(b_rdata[1]),
        .mem_rd(b_mrd), .mem_wr(b_mwr), .mem_addr(b_maddr), .mem_wdata(b_mwd),
        .mem_rdata(b_mrdata)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_rst();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("a_gnt_1hot", 32'(&a_gnt), 32'h0);
            chk("a_rv_1hot",  32'(&a_rv), 32'h0);
            chk("a_strobes",  32'(a_mrd & a_mwr), 32'h0);
            chk("b_gnt_1hot", 32'(&b_gnt), 32'h0);
            chk("b_rv_1hot",  32'(&b_rv), 32'h0);
            chk("b_strobes",  32'(b_mrd & b_mwr), 32'h0);
            a_gn  += $countones(a_gnt);
            a_rvn += $countones(a_rv);
            b_gn  += $countones(b_gnt);
            b_rvn += $countones(b_rv);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lastc;
        tick(2);
        chk("rst_a_out", 32'({a_gnt, a_rv, a_mrd, a_mwr}), 32'h0);
        chk("rst_a_addr", a_maddr, 32'h0);
        chk("rst_a_wd", a_mwd, 32'h0);
        chk("rst_a_rd0", a_rdata[0], 32'h0);
        chk("rst_b_out", 32'({b_gnt, b_rv, b_mrd, b_mwr}), 32'h0);
        rst = 1'b1;
        tick();

        // single read on port 0
        a_req[0] = 1'b1; a_we[0] = 1'b0; a_addr[0] = 32'h10;
        tick();
        chk("t1_gnt", 32'(a_gnt), 32'h1);
        chk("t1_strobe", 32'({a_mrd, a_mwr}), 32'h2);
        chk("t1_addr", a_maddr, 32'h10);
        a_req[0] = 1'b0;
        tick();
        chk("t1_c2", 32'({a_gnt, a_rv, a_mrd, a_mwr}), 32'h0);
        tick();
        chk("t1_rv", 32'(a_rv), 32'h1);
        chk("t1_rdata", a_rdata[0], 32'hDEADBEEF);
        chk("t1_m1_rdata", a_rdata[1], 32'h0);
        tick();
        chk("t1_rv_pulse", 32'(a_rv), 32'h0);
        chk("t1_hold", a_rdata[0], 32'hDEADBEEF);

        // round-robin contention from reset
        do_rst();
        a_req = 2'b11; a_we = 2'b00; a_addr[0] = 32'h100; a_addr[1] = 32'h200;
        n = 0; lastc = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            tick();
            if (a_gnt != 2'b00) begin
                chk($sformatf("t2_rr_port%0d", n), 32'(a_gnt), (n % 2 == 0) ? 32'h1 : 32'h2);
                if (n > 0) chk($sformatf("t2_rr_gap%0d", n), 32'(c - lastc), 32'd3);
                lastc = c;
                n++;
            end
        end
        chk("t2_rr_count", 32'(n), 32'd4);
        a_req = 2'b00;
        tick(5);
        chk("t2_rd0", a_rdata[0], 32'hA5A50100);
        chk("t2_rd1", a_rdata[1], 32'hA5A50200);

        // port 1 write
        a_req[1] = 1'b1; a_we[1] = 1'b1; a_addr[1] = 32'h20; a_wd[1] = 32'h12345678;
        tick();
        chk("t3_gnt", 32'(a_gnt), 32'h2);
        chk("t3_strobe", 32'({a_mrd, a_mwr}), 32'h1);
        chk("t3_addr", a_maddr, 32'h20);
        chk("t3_wdata", a_mwd, 32'h12345678);
        a_req[1] = 1'b0; a_we[1] = 1'b0; a_addr[1] = 32'h99; a_wd[1] = 32'h0;
        tick();
        chk("t3_wr_pulse", 32'(a_mwr), 32'h0);
        chk("t3_addr_hold", a_maddr, 32'h20);
        tick();
        chk("t3_ack", 32'(a_rv), 32'h2);
        chk("t3_rd1_kept", a_rdata[1], 32'hA5A50200);

        // reset during WAIT of a read
        tick();
        a_req[0] = 1'b1; a_addr[0] = 32'h30;
        tick();
        chk("t4_gnt", 32'(a_gnt), 32'h1);
        a_req[0] = 1'b0;
        tick();
        #2 rst = 1'b0;
        #1;
        chk("t4_async_out", 32'({a_gnt, a_rv, a_mrd, a_mwr}), 32'h0);
        chk("t4_async_addr", a_maddr, 32'h0);
        chk("t4_async_rd0", a_rdata[0], 32'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("t4_no_rv%0d", c), 32'(a_rv), 32'h0);
        end
        a_req[0] = 1'b1; a_addr[0] = 32'h10;
        tick();
        chk("t4_regnt", 32'(a_gnt), 32'h1);
        a_req[0] = 1'b0;
        tick(2);
        chk("t4_rv", 32'(a_rv), 32'h1);
        chk("t4_rdata", a_rdata[0], 32'hDEADBEEF);

        // MEM_LAT=3 read on port 1, stray 1-cycle req on port 0 while waiting
        b_req[1] = 1'b1; b_we[1] = 1'b0; b_addr[1] = 32'h40;
        tick();
        chk("t5_gnt", 32'(b_gnt), 32'h2);
        chk("t5_rd", 32'(b_mrd), 32'h1);
        b_req[1] = 1'b0;
        tick();
        chk("t5_c2", 32'({b_gnt, b_rv, b_mrd}), 32'h0);
        b_req[0] = 1'b1; b_addr[0] = 32'h50;
        tick();
        b_req[0] = 1'b0;
        chk("t5_c3", 32'({b_gnt, b_rv}), 32'h0);
        tick();
        chk("t5_c4", 32'({b_gnt, b_rv}), 32'h0);
        tick();
        chk("t5_rv", 32'(b_rv), 32'h2);
        chk("t5_rdata", b_rdata[1], 32'hA5A50040);
        chk("t5_rd0", b_rdata[0], 32'h0);
        tick();
        chk("t5_c6_gnt", 32'(b_gnt), 32'h0);
        tick();
        chk("t5_c7_gnt", 32'(b_gnt), 32'h0);

        // fixed priority contention: port 1 starves
        b_req = 2'b11; b_we = 2'b00; b_addr[0] = 32'h100; b_addr[1] = 32'h200;
        n = 0; lastc = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            tick();
            if (b_gnt != 2'b00) begin
                chk($sformatf("t2_fp_port%0d", n), 32'(b_gnt), 32'h1);
                if (n > 0) chk($sformatf("t2_fp_gap%0d", n), 32'(c - lastc), 32'd5);
                lastc = c;
                n++;
            end
        end
        chk("t2_fp_count", 32'(n), 32'd3);
        b_req = 2'b00;
        tick(8);
        chk("t2_fp_rd0", b_rdata[0], 32'hA5A50100);
        chk("t2_fp_rd1", b_rdata[1], 32'hA5A50040);

        chk("a_gnt_vs_rv", 32'(a_gn), 32'(a_rvn + 1));
        chk("b_gnt_vs_rv", 32'(b_gn), 32'(b_rvn));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
